// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares the single cache memory port between I-cache refills and D-cache accesses.
// Build option ARB_ROUND_ROBIN_EN: round-robin tie-break instead of I priority with starvation guard.
module mem_req_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_strobe,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  input  logic        d_strobe,
  input  logic [31:0] d_addr,
  input  logic        d_write,
  input  logic [1:0]  d_size,
  input  logic [3:0]  d_sel,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] rdata,
  output logic [31:0] mem_a,
  output logic        mem_access,
  output logic        mem_write,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_sel,
  output logic [31:0] mem_st_data,
  input  logic        mem_ready,
  input  logic [31:0] mem_data,
  output logic        grant_d
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic             pick_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;  // 1 = data was granted last

  assign pick_d = d_strobe && (!i_strobe || !last_grant);
`else
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  assign pick_d = d_strobe && (!i_strobe || (starve_cnt == STARVE_LIM));
`endif

  // Completion pulses follow mem_ready in the same cycle, gated by reset.
  assign i_ready = !rst && mem_ready && (state == BUSY_I);
  assign d_ready = !rst && mem_ready && (state == BUSY_D);
  assign rdata   = mem_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      mem_access  <= 1'b0;
      mem_write   <= 1'b0;
      mem_a       <= '0;
      mem_size    <= '0;
      mem_sel     <= '0;
      mem_st_data <= '0;
      grant_d     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_d) begin
            state       <= BUSY_D;
            mem_access  <= 1'b1;
            grant_d     <= 1'b1;
            mem_a       <= d_addr;
            mem_write   <= d_write;
            mem_size    <= d_size;
            mem_sel     <= d_sel;
            mem_st_data <= d_wdata;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant  <= 1'b1;
`else
            starve_cnt  <= '0;
`endif
          end else if (i_strobe) begin
            state       <= BUSY_I;
            mem_access  <= 1'b1;
            grant_d     <= 1'b0;
            mem_a       <= i_addr;
            mem_write   <= 1'b0;
            mem_size    <= 2'b10;
            mem_sel     <= 4'b1111;
            mem_st_data <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant  <= 1'b0;
`else
            // Count instruction wins against a waiting data request.
            if (d_strobe && (starve_cnt != STARVE_LIM)) begin
              starve_cnt <= starve_cnt + CNT_W'(1);
            end
`endif
          end
        end
        BUSY_I, BUSY_D: begin
          // Request fields stay frozen; only completion releases the port.
          if (mem_ready) begin
            state      <= IDLE;
            mem_access <= 1'b0;
            grant_d    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: table vectors, directed corner sequences and randomized traffic
// checked against a grant-policy model of the arbiter.
module tb_mem_req_arbiter;

  localparam int unsigned STARVE = 2;

  logic        clk, rst;
  logic        i_strobe, i_ready;
  logic [31:0] i_addr;
  logic        d_strobe, d_write, d_ready;
  logic [31:0] d_addr, d_wdata;
  logic [1:0]  d_size;
  logic [3:0]  d_sel;
  logic [31:0] rdata, mem_a, mem_st_data, mem_data;
  logic        mem_access, mem_write, mem_ready, grant_d;
  logic [1:0]  mem_size;
  logic [3:0]  mem_sel;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] a;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } pay_t;

  typedef struct {
    logic        is_d;
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  sel;
    logic [31:0] wdata;
    int          lat;
    pay_t        exp;
  } vec_t;

  // Policy model state: instruction wins since data last won, and last granted side.
  int   streak;
  logic last_d;

  mem_req_arbiter #(.STARVE_MAX(STARVE)) dut (
    .clk(clk), .rst(rst),
    .i_strobe(i_strobe), .i_addr(i_addr), .i_ready(i_ready),
    .d_strobe(d_strobe), .d_addr(d_addr), .d_write(d_write), .d_size(d_size),
    .d_sel(d_sel), .d_wdata(d_wdata), .d_ready(d_ready),
    .rdata(rdata), .mem_a(mem_a), .mem_access(mem_access), .mem_write(mem_write),
    .mem_size(mem_size), .mem_sel(mem_sel), .mem_st_data(mem_st_data),
    .mem_ready(mem_ready), .mem_data(mem_data), .grant_d(grant_d)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s actual=%h required=%h at %0t", tag, what, act, exp, $time);
    end
  endtask

  function automatic logic model_pick_d(input logic i, input logic d);
    if (!d) return 1'b0;
    if (!i) return 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
    return !last_d;
`else
    return streak >= int'(STARVE);
`endif
  endfunction

  task automatic model_update(input logic got_d, input logic d_waiting);
    last_d = got_d;
    if (got_d) streak = 0;
    else if (d_waiting && streak < int'(STARVE)) streak++;
  endtask

  function automatic pay_t exp_payload(input logic is_d);
    pay_t p;
    if (is_d) p = '{a: d_addr, wr: d_write, size: d_size, sel: d_sel, wdata: d_wdata};
    else      p = '{a: i_addr, wr: 1'b0, size: 2'b10, sel: 4'hF, wdata: 32'h0};
    return p;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; i_strobe = 1'b0; d_strobe = 1'b0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    streak = 0;
    last_d = 1'b0;
  endtask

  // One full transaction: grant, frozen hold for lat cycles, completion, release.
  task automatic do_txn(input string tag, input logic exp_d, input pay_t ep, input int lat, input logic drop);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      @(negedge clk);
      seen = mem_access;
    end
    if (!seen) begin
      chk(tag, "grant_timeout", 32'd0, 32'd1);
      return;
    end
    chk(tag, "grant_d", 32'(grant_d), 32'(exp_d));
    chk(tag, "mem_a", mem_a, ep.a);
    chk(tag, "mem_write", 32'(mem_write), 32'(ep.wr));
    chk(tag, "mem_size", 32'(mem_size), 32'(ep.size));
    chk(tag, "mem_sel", 32'(mem_sel), 32'(ep.sel));
    chk(tag, "mem_st_data", mem_st_data, ep.wdata);
    for (int k = 0; k < lat; k++) begin
      @(posedge clk);
      #1;
      if (drop && k == 0) begin
        if (exp_d) d_strobe = 1'b0;
        else       i_strobe = 1'b0;
      end
      @(negedge clk);
      chk(tag, "hold_access", 32'(mem_access), 32'd1);
      chk(tag, "hold_a", mem_a, ep.a);
      chk(tag, "hold_st_data", mem_st_data, ep.wdata);
      chk(tag, "hold_grant_d", 32'(grant_d), 32'(exp_d));
      chk(tag, "early_ready", 32'({i_ready, d_ready}), 32'd0);
    end
    mem_data  = $urandom();
    mem_ready = 1'b1;
    #1;
    chk(tag, "i_ready", 32'(i_ready), 32'(!exp_d));
    chk(tag, "d_ready", 32'(d_ready), 32'(exp_d));
    chk(tag, "rdata", rdata, mem_data);
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    @(negedge clk);
    chk(tag, "release_access", 32'(mem_access), 32'd0);
    chk(tag, "release_grant_d", 32'(grant_d), 32'd0);
    chk(tag, "release_ready", 32'({i_ready, d_ready}), 32'd0);
  endtask

  vec_t       vecs[4];
  logic [5:0] order;
  pay_t       ep;
  logic       pd, dw;

  initial begin
    vecs[0] = '{1'b0, 32'hBFC0_0000, 1'b1, 2'b01, 4'h3, 32'hDEAD_BEEF, 3,
                '{32'hBFC0_0000, 1'b0, 2'b10, 4'hF, 32'h0}};
    vecs[1] = '{1'b1, 32'h8000_0010, 1'b1, 2'b10, 4'b0011, 32'h1234_ABCD, 2,
                '{32'h8000_0010, 1'b1, 2'b10, 4'b0011, 32'h1234_ABCD}};
    vecs[2] = '{1'b1, 32'hA000_0203, 1'b0, 2'b00, 4'b1000, 32'h5555_AAAA, 0,
                '{32'hA000_0203, 1'b0, 2'b00, 4'b1000, 32'h5555_AAAA}};
    vecs[3] = '{1'b0, 32'h0000_0FFC, 1'b1, 2'b11, 4'h0, 32'hFFFF_FFFF, 0,
                '{32'h0000_0FFC, 1'b0, 2'b10, 4'hF, 32'h0}};

    rst = 1'b1; i_strobe = 1'b1; d_strobe = 1'b1; mem_ready = 1'b1;
    i_addr = 32'h1111_1110; d_addr = 32'h2222_2222; d_write = 1'b1;
    d_size = 2'b11; d_sel = 4'hF; d_wdata = 32'h3333_3333; mem_data = 32'hCAFE_F00D;
    streak = 0; last_d = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset", "mem_access", 32'(mem_access), 32'd0);
    chk("reset", "mem_a", mem_a, 32'd0);
    chk("reset", "mem_fields", 32'({mem_write, mem_size, mem_sel}), 32'd0);
    chk("reset", "mem_st_data", mem_st_data, 32'd0);
    chk("reset", "grant_d", 32'(grant_d), 32'd0);
    chk("reset", "readies", 32'({i_ready, d_ready}), 32'd0);
    chk("reset", "rdata", rdata, 32'hCAFE_F00D);
    do_reset();

    // Table vectors: one requester at a time.
    foreach (vecs[n]) begin
      i_addr = vecs[n].addr;
      d_addr = vecs[n].addr; d_write = vecs[n].wr; d_size = vecs[n].size;
      d_sel = vecs[n].sel; d_wdata = vecs[n].wdata;
      i_strobe = !vecs[n].is_d;
      d_strobe = vecs[n].is_d;
      do_txn($sformatf("vec%0d", n), vecs[n].is_d, vecs[n].exp, vecs[n].lat, 1'b0);
      i_strobe = 1'b0; d_strobe = 1'b0;
    end

    // Strobe drop mid-transaction.
    i_addr = 32'h0040_1000; i_strobe = 1'b1;
    do_txn("drop", 1'b0, exp_payload(1'b0), 3, 1'b1);

    // mem_ready while idle is ignored.
    mem_ready = 1'b1;
    @(negedge clk);
    chk("idle_ready", "readies", 32'({i_ready, d_ready}), 32'd0);
    @(negedge clk);
    chk("idle_ready", "mem_access", 32'(mem_access), 32'd0);
    mem_ready = 1'b0;

    // Reset mid-transaction in BUSY_D.
    d_addr = 32'h9000_0040; d_write = 1'b0; d_strobe = 1'b1;
    pd = 1'b0;
    for (int k = 0; k < 6 && !pd; k++) begin
      @(negedge clk);
      pd = mem_access;
    end
    chk("rst_mid", "grant_d", 32'(grant_d), 32'd1);
    rst = 1'b1; mem_ready = 1'b1;
    #1;
    chk("rst_mid", "d_ready_in_rst", 32'(d_ready), 32'd0);
    @(posedge clk);
    #1;
    d_strobe = 1'b0;
    @(negedge clk);
    chk("rst_mid", "mem_access", 32'(mem_access), 32'd0);
    chk("rst_mid", "grant_d_after", 32'(grant_d), 32'd0);
    rst = 1'b0;
    streak = 0; last_d = 1'b0;
    @(negedge clk);
    chk("rst_mid", "late_ready", 32'({i_ready, d_ready}), 32'd0);
    mem_ready = 1'b0;

    // Both strobes held from the reset state: fixed order from the policy rules.
`ifdef ARB_ROUND_ROBIN_EN
    order = 6'b010101;
`else
    order = 6'b100100;
`endif
    i_addr = 32'hBFC0_0100;
    d_addr = 32'h8000_0200; d_write = 1'b1; d_size = 2'b10; d_sel = 4'hC; d_wdata = 32'h0BAD_CAFE;
    i_strobe = 1'b1; d_strobe = 1'b1;
    for (int k = 0; k < 6; k++) begin
      do_txn($sformatf("tie%0d", k), order[k], exp_payload(order[k]), 1, 1'b0);
    end

    // Randomized traffic against the policy model.
    do_reset();
    for (int n = 0; n < 60; n++) begin
      if (!i_strobe && !d_strobe) begin
        int r;
        r = int'($urandom_range(1, 3));
        if (r[0]) begin i_strobe = 1'b1; i_addr = $urandom() & 32'hFFFF_FFFC; end
        if (r[1]) begin
          d_strobe = 1'b1; d_addr = $urandom(); d_write = 1'($urandom());
          d_size = 2'($urandom()); d_sel = 4'($urandom()); d_wdata = $urandom();
        end
      end
      pd = model_pick_d(i_strobe, d_strobe);
      dw = d_strobe;
      ep = exp_payload(pd);
      do_txn($sformatf("rand%0d", n), pd, ep, int'($urandom_range(0, 3)), 1'b0);
      model_update(pd, dw);
      if (pd) begin
        d_strobe = 1'($urandom());
        d_addr = $urandom(); d_write = 1'($urandom());
        d_size = 2'($urandom()); d_sel = 4'($urandom()); d_wdata = $urandom();
        if (!i_strobe) begin i_strobe = 1'($urandom()); i_addr = $urandom() & 32'hFFFF_FFFC; end
      end else begin
        i_strobe = 1'($urandom());
        i_addr = $urandom() & 32'hFFFF_FFFC;
        if (!d_strobe) begin
          d_strobe = 1'($urandom());
          d_addr = $urandom(); d_write = 1'($urandom());
          d_size = 2'($urandom()); d_sel = 4'($urandom()); d_wdata = $urandom();
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
